// File: rtl/guess_input_reader_if.sv
// ----------------------------------------------------------------------------
// guess_input_reader_if
//   Guess hand-off bundle between the input reader and the Bulls and Cows core.
//   master (reader side) : drives guess_valid, guess, reject, err_code;
//                          samples guess_ready
//   slave  (core side)   : the mirror image
//   guess_valid  guess is held and offered
//   guess_ready  core accepts the guess this cycle
//   guess        latched guess, four BCD nibbles, digit 3 most significant
//   reject       one-cycle pulse: the last press carried an invalid guess
//   err_code     0 none, 1 bad digit (nibble > 9), 2 duplicate digit
// ----------------------------------------------------------------------------
interface guess_input_reader_if;
   logic        guess_valid;
   logic        guess_ready;
   logic [15:0] guess;
   logic        reject;
   logic [1:0]  err_code;

   modport master (
      output guess_valid,
      output guess,
      output reject,
      output err_code,
      input  guess_ready
   );

   modport slave (
      input  guess_valid,
      input  guess,
      input  reject,
      input  err_code,
      output guess_ready
   );
endinterface

// File: rtl/guess_input_reader.sv
// ----------------------------------------------------------------------------
// guess_input_reader
//   Reads the player's 4-digit guess from the board switches when the confirm
//   button is pressed, validates it and hands it to the Bulls and Cows core.
//   The raw button is synchronised and debounced, the switches synchronised;
//   a valid guess is offered over valid/ready, an invalid one is flagged with
//   a one-cycle reject pulse plus an error code.
//
//   Parameters
//     DEBOUNCE_CYCLES   stable cycles before a new button level is accepted
//     REQUIRE_DISTINCT  1: the four digits must be pairwise different
//   Ports
//     clock    system clock, rising edge
//     reset    asynchronous, active-low reset
//     btn_raw  raw confirm push-button, asynchronous, active-high
//     SW       raw switches, digit i = SW[4i+3:4i]
//     busy     high whenever the reader is not idle
//     gif      guess hand-off bundle (master side)
// ----------------------------------------------------------------------------
module guess_input_reader #(
   parameter int unsigned DEBOUNCE_CYCLES  = 1_000_000,
   parameter bit          REQUIRE_DISTINCT = 1'b1
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 btn_raw,
   input  logic [15:0]          SW,
   output logic                 busy,
   guess_input_reader_if.master gif
);

   localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE,
      CHECK,
      OFFER,
      WAIT_RELEASE
   } state_t;

   typedef enum logic [1:0] {
      ERR_NONE      = 2'd0,
      ERR_BAD_DIGIT = 2'd1,
      ERR_DUPLICATE = 2'd2
   } err_t;

   // ---------------------------------------------------------------- sync
   logic [1:0]  btn_sync_q;
   logic [15:0] sw_meta_q;
   logic [15:0] sw_sync_q;

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples the pre-edge value of its neighbours, as the hardware does.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         btn_sync_q <= '0;
         sw_meta_q  <= '0;
         sw_sync_q  <= '0;
      end else begin
         btn_sync_q <= {btn_sync_q[0], btn_raw};
         sw_meta_q  <= SW;
         sw_sync_q  <= sw_meta_q;
      end
   end

   // ------------------------------------------------------------ debounce
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             level_q, level_d;
   logic             press_q;

   // NOTE: every variable written here gets a default first, so no path
   // leaves it unassigned and no latch is inferred.
   always_comb begin
      cnt_d   = '0;
      level_d = level_q;
      if (btn_sync_q[1] != level_q) begin
         if (cnt_q == CNT_MAX) begin
            level_d = ~level_q;        // counter restarts from zero
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         cnt_q   <= '0;
         level_q <= 1'b0;
         press_q <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         level_q <= level_d;
         // One-cycle pulse in the first cycle the debounced level reads 1.
         press_q <= level_d & ~level_q;
      end
   end

   // ----------------------------------------------------------- validation
   logic [15:0] snapshot_q;
   logic        bad_digit;
   logic        duplicate;
   err_t        err_d;

   always_comb begin
      bad_digit = 1'b0;
      duplicate = 1'b0;
      err_d     = ERR_NONE;
      for (int i = 0; i < 4; i++) begin
         if (snapshot_q[4*i +: 4] > 4'd9) bad_digit = 1'b1;
      end
      for (int i = 0; i < 3; i++) begin
         for (int j = i + 1; j < 4; j++) begin
            if (snapshot_q[4*i +: 4] == snapshot_q[4*j +: 4]) duplicate = 1'b1;
         end
      end
      // A bad digit outranks a duplicate.
      if (bad_digit) begin
         err_d = ERR_BAD_DIGIT;
      end else if (REQUIRE_DISTINCT && duplicate) begin
         err_d = ERR_DUPLICATE;
      end
   end

   // ------------------------------------------------------------------ FSM
   state_t      state_q;
   logic [15:0] guess_q;
   logic        valid_q;
   logic        reject_q;
   err_t        err_q;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q    <= IDLE;
         snapshot_q <= '0;
         guess_q    <= '0;
         valid_q    <= 1'b0;
         reject_q   <= 1'b0;
         err_q      <= ERR_NONE;
      end else begin
         reject_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (press_q) begin
                  snapshot_q <= sw_sync_q;
                  state_q    <= CHECK;
               end
            end
            CHECK: begin
               err_q <= err_d;
               if (err_d == ERR_NONE) begin
                  guess_q <= snapshot_q;
                  valid_q <= 1'b1;
                  state_q <= OFFER;
               end else begin
                  reject_q <= 1'b1;
                  state_q  <= WAIT_RELEASE;
               end
            end
            OFFER: begin
               // Presses here are ignored; guess_q stays put after hand-off.
               if (valid_q && gif.guess_ready) begin
                  valid_q <= 1'b0;
                  state_q <= WAIT_RELEASE;
               end
            end
            WAIT_RELEASE: begin
               // A held button must be released before the next guess.
               if (!level_q) state_q <= IDLE;
            end
         endcase
      end
   end

   assign gif.guess_valid = valid_q;
   assign gif.guess       = guess_q;
   assign gif.reject      = reject_q;
   assign gif.err_code    = err_q;
   assign busy            = (state_q != IDLE);

endmodule

// File: tb/tb_guess_input_reader.sv
// ----------------------------------------------------------------------------
// tb_guess_input_reader
//   Two readers share button, switches and guess_ready: one requires distinct
//   digits, the other allows repeats. Each press that should be accepted
//   pushes the model's expected outcome into a per-reader queue; a monitor
//   on the falling edge pops and compares whenever a reader presents a
//   reject pulse or a guess hand-off.
// ----------------------------------------------------------------------------
module tb_guess_input_reader;

   localparam int DEB = 4;

   logic        clock   = 1'b0;
   logic        reset   = 1'b0;
   logic        btn_raw = 1'b0;
   logic [15:0] SW      = '0;
   logic        rdy     = 1'b0;
   logic        busy0, busy1;

   guess_input_reader_if gif0 ();
   guess_input_reader_if gif1 ();

   assign gif0.guess_ready = rdy;
   assign gif1.guess_ready = rdy;

   guess_input_reader #(.DEBOUNCE_CYCLES(DEB), .REQUIRE_DISTINCT(1'b1)) dut0 (
      .clock   (clock),
      .reset   (reset),
      .btn_raw (btn_raw),
      .SW      (SW),
      .busy    (busy0),
      .gif     (gif0.master)
   );

   guess_input_reader #(.DEBOUNCE_CYCLES(DEB), .REQUIRE_DISTINCT(1'b0)) dut1 (
      .clock   (clock),
      .reset   (reset),
      .btn_raw (btn_raw),
      .SW      (SW),
      .busy    (busy1),
      .gif     (gif1.master)
   );

   always #5 clock = ~clock;

   // Per-reader views so the monitor can loop over both.
   logic [1:0]  vld, rej, bsy;
   logic [15:0] g  [2];
   logic [1:0]  ec [2];
   assign vld   = {gif1.guess_valid, gif0.guess_valid};
   assign rej   = {gif1.reject, gif0.reject};
   assign bsy   = {busy1, busy0};
   assign g[0]  = gif0.guess;
   assign g[1]  = gif1.guess;
   assign ec[0] = gif0.err_code;
   assign ec[1] = gif1.err_code;

   typedef struct packed {
      logic        is_reject;
      logic [15:0] guess;
      logic [1:0]  err;
   } exp_t;

   exp_t q0[$];
   exp_t q1[$];
   int   checks = 0;
   int   errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: decide the outcome of a guess from the digit rules.
   function automatic exp_t model(input logic [15:0] sw, input bit distinct);
      int   seen [10];
      bit   bad = 1'b0;
      bit   dup = 1'b0;
      exp_t e;
      foreach (seen[k]) seen[k] = 0;
      for (int i = 0; i < 4; i++) begin
         int d = int'(sw[4*i +: 4]);
         if (d > 9) bad = 1'b1;
         else begin
            if (seen[d] != 0) dup = 1'b1;
            seen[d]++;
         end
      end
      e.guess     = sw;
      e.is_reject = bad || (distinct && dup);
      e.err       = bad ? 2'd1 : (distinct && dup) ? 2'd2 : 2'd0;
      return e;
   endfunction

   function automatic int qsize(input int i);
      return (i == 0) ? q0.size() : q1.size();
   endfunction

   function automatic exp_t qfront(input int i);
      return (i == 0) ? q0[0] : q1[0];
   endfunction

   function automatic exp_t qpop(input int i);
      if (i == 0) return q0.pop_front();
      return q1.pop_front();
   endfunction

   task automatic unexpected(input int i, input string what);
      checks++;
      errors++;
      $display("FAIL unexpected_%s%0d: got an output, expected none (t=%0t)", what, i, $time);
   endtask

   task automatic monitor_one(input int i);
      exp_t e;
      if (rej[i]) begin
         if (qsize(i) == 0) unexpected(i, "reject");
         else begin
            e = qpop(i);
            check($sformatf("kind_reject%0d", i), 32'd1, {31'd0, e.is_reject});
            check($sformatf("err_code_reject%0d", i), {30'd0, ec[i]}, {30'd0, e.err});
            check($sformatf("valid_with_reject%0d", i), {31'd0, vld[i]}, 32'd0);
         end
      end else if (vld[i]) begin
         if (qsize(i) == 0) unexpected(i, "valid");
         else begin
            e = qfront(i);
            check($sformatf("kind_valid%0d", i), 32'd0, {31'd0, e.is_reject});
            check($sformatf("guess%0d", i), {16'd0, g[i]}, {16'd0, e.guess});
            check($sformatf("err_code_valid%0d", i), {30'd0, ec[i]}, {30'd0, e.err});
            if (rdy) void'(qpop(i));
         end
      end
   endtask

   always @(negedge clock) begin
      if (reset) begin
         for (int i = 0; i < 2; i++) monitor_one(i);
      end
   end

   // ------------------------------------------------------------ stimulus
   task automatic tick(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   task automatic push_expected(input logic [15:0] sw);
      q0.push_back(model(sw, 1'b1));
      q1.push_back(model(sw, 1'b0));
   endtask

   // Clean press: switches and button change together, held 'hold' cycles.
   task automatic press(input logic [15:0] sw, input bit accepted, input int hold);
      SW = sw;
      if (accepted) push_expected(sw);
      btn_raw = 1'b1;
      tick(hold);
      btn_raw = 1'b0;
   endtask

   task automatic check_all_zero(input string tag);
      for (int i = 0; i < 2; i++) begin
         check($sformatf("%s_valid%0d", tag, i), {31'd0, vld[i]}, 32'd0);
         check($sformatf("%s_guess%0d", tag, i), {16'd0, g[i]}, 32'd0);
         check($sformatf("%s_reject%0d", tag, i), {31'd0, rej[i]}, 32'd0);
         check($sformatf("%s_err%0d", tag, i), {30'd0, ec[i]}, 32'd0);
         check($sformatf("%s_busy%0d", tag, i), {31'd0, bsy[i]}, 32'd0);
      end
   endtask

   function automatic logic [15:0] random_sw(input int mode);
      logic [15:0] sw;
      int          d [10];
      int          j, t;
      sw = '0;
      case (mode)
         0: sw = 16'($urandom);
         1: for (int i = 0; i < 4; i++) sw[4*i +: 4] = 4'($urandom_range(9, 0));
         default: begin
            for (int k = 0; k < 10; k++) d[k] = k;
            for (int k = 9; k > 0; k--) begin
               j = int'($urandom_range(k, 0));
               t = d[k]; d[k] = d[j]; d[j] = t;
            end
            for (int i = 0; i < 4; i++) sw[4*i +: 4] = 4'(d[i]);
         end
      endcase
      return sw;
   endfunction

   initial begin
      bit seen_offer;

      // Reset state.
      tick(3);
      check_all_zero("reset");
      reset = 1'b1;
      tick(3);

      // Valid guess, button held, core always ready.
      rdy = 1'b1;
      press(16'h1234, 1'b1, 10);
      tick(20);

      // Bad digit.
      press(16'h1A34, 1'b1, 10);
      tick(20);

      // Repeated digit: rejected by the distinct reader, accepted by the other.
      press(16'h1231, 1'b1, 10);
      tick(20);

      // Core stalls; a second press with new switches during the offer is ignored.
      rdy = 1'b0;
      press(16'h5678, 1'b1, 10);
      tick(10);
      press(16'h0000, 1'b0, 10);
      tick(20);
      rdy = 1'b1;
      tick(20);

      // Short glitch, then a 1-0-1 bounce before a stable press.
      SW = 16'h9876;
      btn_raw = 1'b1;
      tick(2);
      btn_raw = 1'b0;
      tick(15);
      push_expected(16'h9876);
      btn_raw = 1'b1; tick(1);
      btn_raw = 1'b0; tick(1);
      btn_raw = 1'b1; tick(10);
      btn_raw = 1'b0;
      tick(20);

      // Randomised presses with random stalls; switches scrambled after the press.
      repeat (40) begin
         int hold;
         hold = int'($urandom_range(12, 8));
         SW = random_sw(int'($urandom_range(2, 0)));
         push_expected(SW);
         btn_raw = 1'b1;
         for (int k = 0; k < hold; k++) begin
            rdy = 1'($urandom);
            tick(1);
         end
         btn_raw = 1'b0;
         SW = 16'($urandom);
         for (int k = 0; k < 8; k++) begin
            rdy = 1'($urandom);
            tick(1);
         end
         rdy = 1'b1;
         tick(15);
      end

      // Reset in the middle of an offer drops the pending guess.
      rdy = 1'b0;
      press(16'h2468, 1'b1, 10);
      seen_offer = 1'b0;
      for (int k = 0; k < 30 && !seen_offer; k++) begin
         if (gif0.guess_valid && gif1.guess_valid) seen_offer = 1'b1;
         else tick(1);
      end
      check("offer_before_reset", {31'd0, seen_offer}, 32'd1);
      reset = 1'b0;
      #1;
      check_all_zero("async_reset");
      q0.delete();
      q1.delete();
      tick(2);
      reset = 1'b1;
      tick(3);
      check("busy_after_reset0", {31'd0, busy0}, 32'd0);
      check("busy_after_reset1", {31'd0, busy1}, 32'd0);
      rdy = 1'b1;
      press(16'h1234, 1'b1, 10);
      tick(20);

      // Every expected outcome must have been observed.
      for (int k = 0; k < 200 && (q0.size() != 0 || q1.size() != 0); k++) tick(1);
      check("drain0", q0.size(), 32'd0);
      check("drain1", q1.size(), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

endmodule
